// File: rtl/c2h_pkt_pkg.sv
// Shared types for the C2H packetizer: FSM states, header layout and magic.
package c2h_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } c2h_state_e;

  localparam logic [15:0] HDR_MAGIC = 16'hA5C3;

  typedef struct packed {
    logic [15:0] magic;
    logic [15:0] pkt_words;
    logic [31:0] seq;
  } c2h_hdr_t;

  function automatic c2h_hdr_t make_hdr(input logic [15:0] words, input logic [31:0] seq);
    c2h_hdr_t h;
    h.magic     = HDR_MAGIC;
    h.pkt_words = words;
    h.seq       = seq;
    return h;
  endfunction

endpackage

// File: rtl/c2h_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout always shows the head word.
module c2h_sync_fifo #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  din,
  output logic              full,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  dout,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              do_wr, do_rd;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/c2h_packetizer.sv
// Packs 32-bit samples into 64-bit words and emits fixed-length AXI-Stream packets
// only once a whole packet is buffered. Define C2H_PKT_HDR_EN to prepend a header beat.
module c2h_packetizer #(
  parameter int          TCQ          = 1,
  parameter int unsigned C_DATA_WIDTH = 64,
  parameter int unsigned IN_WIDTH     = 32,
  parameter int unsigned FIFO_ADDR_W  = 9,
  parameter int unsigned PKT_WORDS    = 256
) (
  input  logic                      user_clk,
  input  logic                      sys_reset,
  input  logic                      enable,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_valid,
  output logic [C_DATA_WIDTH-1:0]   s_axis_c2h_tdata_0,
  output logic [C_DATA_WIDTH/8-1:0] s_axis_c2h_tkeep_0,
  output logic                      s_axis_c2h_tlast_0,
  output logic                      s_axis_c2h_tvalid_0,
  input  logic                      s_axis_c2h_tready_0,
  output logic [31:0]               pkt_cnt,
  output logic [15:0]               drop_cnt,
  output logic                      overflow,
  output logic [FIFO_ADDR_W:0]      fifo_level
);

  import c2h_pkt_pkg::*;

  localparam int unsigned BEAT_W = $clog2(PKT_WORDS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_WORDS - 1);
  localparam logic [FIFO_ADDR_W:0] PKT_LVL = (FIFO_ADDR_W+1)'(PKT_WORDS);

  if (C_DATA_WIDTH != 64 || IN_WIDTH * 2 != C_DATA_WIDTH || PKT_WORDS < 2 ||
      PKT_WORDS > (1 << FIFO_ADDR_W) || TCQ < 0) begin : g_cfg_err
    $error("c2h_packetizer: unsupported parameter set");
  end

  c2h_state_e             state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [31:0]            pkt_cnt_q, pkt_cnt_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic                   overflow_q, overflow_d;
  logic                   phase_q, phase_d;
  logic [IN_WIDTH-1:0]    low_q, low_d;

  logic                   word_wr;
  logic                   fifo_full, fifo_empty;
  logic [C_DATA_WIDTH-1:0] fifo_dout;
  logic                   xfer, last_beat, pop;

  c2h_sync_fifo #(
    .WIDTH  (C_DATA_WIDTH),
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk   (user_clk),
    .rst   (sys_reset),
    .wr_en (word_wr),
    .din   ({in_data, low_q}),
    .full  (fifo_full),
    .rd_en (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign xfer      = s_axis_c2h_tvalid_0 && s_axis_c2h_tready_0;
  assign last_beat = (state_q == SEND) && (beat_q == LAST_BEAT);
  assign pop       = xfer && (state_q == SEND) && !fifo_empty;

  // Packer: a word is only formed on the second sample of a pair.
  always_comb begin
    phase_d = phase_q;
    low_d   = low_q;
    word_wr = 1'b0;
    if (!enable) begin
      phase_d = 1'b0;
    end else if (in_valid) begin
      if (!phase_q) begin
        low_d   = in_data;
        phase_d = 1'b1;
      end else begin
        word_wr = 1'b1;
        phase_d = 1'b0;
      end
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (word_wr && fifo_full) begin
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (enable && fifo_level >= PKT_LVL) begin
`ifdef C2H_PKT_HDR_EN
          state_d = HDR;
`else
          state_d = SEND;
`endif
        end
      end
`ifdef C2H_PKT_HDR_EN
      HDR: if (s_axis_c2h_tready_0) state_d = SEND;
`endif
      SEND: begin
        if (s_axis_c2h_tready_0) begin
          if (last_beat) begin
            state_d   = IDLE;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (sys_reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      phase_q    <= 1'b0;
      low_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      phase_q    <= phase_d;
      low_q      <= low_d;
    end
  end

  // tdata is gated to zero outside a packet so reset and idle show a clean bus.
  always_comb begin
    s_axis_c2h_tdata_0 = '0;
    if (state_q == SEND) s_axis_c2h_tdata_0 = fifo_dout;
`ifdef C2H_PKT_HDR_EN
    if (state_q == HDR) s_axis_c2h_tdata_0 = make_hdr(16'(PKT_WORDS), pkt_cnt_q);
`endif
  end

  assign s_axis_c2h_tkeep_0  = '1;
  assign s_axis_c2h_tvalid_0 = (state_q != IDLE);
  assign s_axis_c2h_tlast_0  = last_beat;
  assign pkt_cnt             = pkt_cnt_q;
  assign drop_cnt            = drop_cnt_q;
  assign overflow            = overflow_q;

endmodule
